// File: rtl/scytale_encryption.sv
// Scytale encryption: buffers plaintext until the start token, then emits it column-major.
// Define SCYTALE_PAD_EN to fill positions past the message end with PAD_CHAR.
module scytale_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR               = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int IDX_W = 2 * KEY_WIDTH;
`ifdef SCYTALE_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] n_q, n_d, m_q, m_d;
    logic [KEY_WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [IDX_W-1:0]     base_q, base_d;
    logic                 done_q, done_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 wr_en;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     msg_len;
    logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

    // base steps by N each row, so the read index needs only an adder.
    assign idx     = base_q + IDX_W'(col_q);
    assign msg_len = IDX_W'(key_N) * IDX_W'(key_M);

    assign busy    = busy_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[cnt_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            n_q     <= '0;
            m_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            m_q     <= m_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        m_d     = m_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        done_d  = done_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        case (state_q)
            COLLECT: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (valid_i) begin
                    if (data_i == START_ENCRYPTION_TOKEN) begin
                        if (key_N == '0 || key_M == '0 ||
                            msg_len > IDX_W'(MAX_NOF_CHARS) || cnt_q == '0) begin
                            cnt_d = '0;
                        end else begin
                            n_d     = key_N;
                            m_d     = key_M;
                            col_d   = '0;
                            row_d   = '0;
                            base_d  = '0;
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                            state_d = EMIT;
                        end
                    end else if (cnt_q < CNT_W'(MAX_NOF_CHARS)) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (done_q) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = COLLECT;
                end else begin
                    if (idx < IDX_W'(cnt_q)) begin
                        data_d  = mem_q[idx[CNT_W-1:0]];
                        valid_d = 1'b1;
                    end else if (PAD_EN) begin
                        data_d  = PAD_CHAR;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                    // Row advances fastest; a finished column moves on to the next one.
                    if (row_q == m_q - KEY_WIDTH'(1)) begin
                        row_d  = '0;
                        base_d = '0;
                        if (col_q == n_q - KEY_WIDTH'(1)) done_d = 1'b1;
                        else col_d = col_q + KEY_WIDTH'(1);
                    end else begin
                        row_d  = row_q + KEY_WIDTH'(1);
                        base_d = base_q + IDX_W'(n_q);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_scytale_encryption.sv
// Bench for scytale_encryption: table vectors, hand sequences and random messages vs a reference model.
module tb_scytale_encryption;

    localparam logic [7:0] TOKEN = 8'hFA;
    localparam int         MAXC  = 50;
`ifdef SCYTALE_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic       busy;
    logic [7:0] data_o;
    logic       valid_o;

    scytale_encryption dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .key_N(key_N), .key_M(key_M),
        .busy(busy), .data_o(data_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] plain_q[$];
    logic [7:0] exp_q[$];
    logic       expv_q[$];
    logic [7:0] got_q[$];
    logic       gotv_q[$];

    // Output collector: every character seen, and valid_o on every busy cycle.
    always @(posedge clk) begin
        #1;
        if (valid_o) got_q.push_back(data_o);
        if (busy) gotv_q.push_back(valid_o);
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: row-major layout of the first min(len,50) chars, read column by column.
    task automatic model(input int n, input int m);
        int cnt;
        int l;
        cnt = (plain_q.size() > MAXC) ? MAXC : plain_q.size();
        l = n * m;
        exp_q.delete();
        expv_q.delete();
        if (n == 0 || m == 0 || l > MAXC || cnt == 0) return;
        expv_q.push_back(1'b0);
        for (int c = 0; c < n; c++) begin
            for (int r = 0; r < m; r++) begin
                if (r * n + c < cnt) begin
                    exp_q.push_back(plain_q[r * n + c]);
                    expv_q.push_back(1'b1);
                end else if (PAD) begin
                    exp_q.push_back(8'h20);
                    expv_q.push_back(1'b1);
                end else begin
                    expv_q.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic put(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
    endtask

    task automatic start_msg(input int n, input int m);
        got_q.delete();
        gotv_q.delete();
        foreach (plain_q[i]) put(1'b1, plain_q[i]);
        key_N = 8'(n);
        key_M = 8'(m);
        put(1'b1, TOKEN);
    endtask

    task automatic finish_msg(input string name);
        int guard;
        int bad;
        put(1'b0, 8'h00);
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(guard < 200, {name, " busy_timeout"}, guard, 200);
        @(negedge clk);
        check(got_q.size() == exp_q.size(), {name, " out_count"}, got_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0) check(1'b0, {name, " out_data"}, got_q[bad], exp_q[bad]);
        else check(1'b1, {name, " out_data"}, 0, 0);
        bad = (gotv_q.size() != expv_q.size()) ? 0 : -1;
        for (int i = 0; i < gotv_q.size() && i < expv_q.size(); i++)
            if (bad < 0 && gotv_q[i] !== expv_q[i]) bad = i;
        check(bad < 0, {name, " valid_timing"}, gotv_q.size(), expv_q.size());
    endtask

    task automatic run_msg(input string name, input int n, input int m);
        model(n, m);
        start_msg(n, m);
        finish_msg(name);
    endtask

    task automatic load_str(input logic [63:0] s, input int len);
        logic [63:0] t;
        plain_q.delete();
        for (int k = 0; k < len; k++) begin
            t = s >> (8 * (len - 1 - k));
            plain_q.push_back(t[7:0]);
        end
    endtask

    typedef struct packed {
        logic [7:0]  n;
        logic [7:0]  m;
        logic [7:0]  pt_len;
        logic [63:0] pt;
        logic [7:0]  np_len;
        logic [63:0] np;
        logic [7:0]  pd_len;
        logic [63:0] pd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [63:0] t;
        int          el;
        logic [63:0] es;
        tbl[0] = '{8'd3, 8'd2, 8'd6, 64'("ABCDEF"), 8'd6, 64'("ADBECF"), 8'd6, 64'("ADBECF")};
        tbl[1] = '{8'd2, 8'd2, 8'd3, 64'("ABC"),    8'd3, 64'("ACB"),    8'd4, 64'("ACB ")};
        tbl[2] = '{8'd0, 8'd2, 8'd2, 64'("AB"),     8'd0, 64'd0,         8'd0, 64'd0};
        tbl[3] = '{8'd2, 8'd1, 8'd2, 64'("XY"),     8'd2, 64'("XY"),     8'd2, 64'("XY")};
        tbl[4] = '{8'd2, 8'd2, 8'd0, 64'd0,         8'd0, 64'd0,         8'd0, 64'd0};
        tbl[5] = '{8'd8, 8'd8, 8'd2, 64'("AB"),     8'd0, 64'd0,         8'd0, 64'd0};
        tbl[6] = '{8'd1, 8'd3, 8'd3, 64'("PQR"),    8'd3, 64'("PQR"),    8'd3, 64'("PQR")};
        tbl[7] = '{8'd3, 8'd1, 8'd4, 64'("PQRS"),   8'd3, 64'("PQR"),    8'd3, 64'("PQR")};

        rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; key_N = 8'd0; key_M = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check(valid_o == 1'b0, "reset valid_o", valid_o, 0);
        check(busy == 1'b0, "reset busy", busy, 0);
        check(data_o == 8'h00, "reset data_o", data_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: model check plus hand-written expected string.
        for (int v = 0; v < 8; v++) begin
            load_str(tbl[v].pt, int'(tbl[v].pt_len));
            run_msg($sformatf("vec%0d", v), int'(tbl[v].n), int'(tbl[v].m));
            el = PAD ? int'(tbl[v].pd_len) : int'(tbl[v].np_len);
            es = PAD ? tbl[v].pd : tbl[v].np;
            check(got_q.size() == el, $sformatf("vec%0d table_len", v), got_q.size(), el);
            for (int k = 0; k < el && k < got_q.size(); k++) begin
                t = es >> (8 * (el - 1 - k));
                if (got_q[k] !== t[7:0])
                    check(1'b0, $sformatf("vec%0d table_char%0d", v, k), got_q[k], t[7:0]);
            end
        end

        // Overflow: 52 chars, only the first 50 are kept.
        plain_q.delete();
        for (int i = 0; i < 52; i++) plain_q.push_back(8'($urandom_range(0, 249)));
        run_msg("overflow", 5, 10);
        check(got_q.size() == 50, "overflow count", got_q.size(), 50);

        // Busy and key isolation: input during EMIT is ignored.
        load_str(64'("ABCDEF"), 6);
        model(3, 2);
        start_msg(3, 2);
        put(1'b1, 8'h5A);
        key_N = 8'd2;
        key_M = 8'd2;
        put(1'b1, TOKEN);
        put(1'b1, 8'h5A);
        finish_msg("isolation");
        load_str(64'("ABCD"), 4);
        run_msg("after_isolation", 2, 2);
        check(got_q.size() == 4 && got_q[1] == 8'h43, "new_key second char", got_q.size() == 4 ? got_q[1] : 0, 8'h43);

        // Reset on the 3rd output cycle.
        begin
            int g;
            load_str(64'("ABCDEF"), 6);
            start_msg(3, 2);
            put(1'b0, 8'h00);
            g = 0;
            while (got_q.size() < 3 && g < 50) begin
                @(posedge clk);
                #2;
                g++;
            end
            check(g < 50, "rst_mid wait_third", g, 50);
            rst = 1'b1;
            @(posedge clk);
            #2;
            check(valid_o == 1'b0, "rst_mid valid_o", valid_o, 0);
            check(busy == 1'b0, "rst_mid busy", busy, 0);
            check(data_o == 8'h00, "rst_mid data_o", data_o, 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check(got_q.size() == 3, "rst_mid no_more_out", got_q.size(), 3);
        end
        load_str(64'("AB"), 2);
        run_msg("after_reset", 2, 1);

        // Random messages against the model.
        for (int r = 0; r < 20; r++) begin
            int len;
            int n;
            int m;
            len = $urandom_range(0, 55);
            n = $urandom_range(0, 8);
            m = $urandom_range(1, 8);
            plain_q.delete();
            for (int i = 0; i < len; i++) plain_q.push_back(8'($urandom_range(0, 249)));
            run_msg($sformatf("rand%0d", r), n, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
